// File: rtl/cp0_excpt_src.sv
// cp0_excpt_src: CP0 Count/Compare/Status/Cause/EPC registers and exception source
// Ports: clk, rst (async active-high); we/waddr/wdata mtc0 write; raddr/rdata mfc0 read;
//        pc, is_syscall, is_eret from the current stage; excptype one-hot event,
//        epc current EPC, timer_int pending Cause.TI.
// Optional: define CP0_CNT_DIV2_EN to make Count advance every second clock.
module cp0_excpt_src #(
    parameter logic [31:0] COUNT_INIT   = 32'h0,
    parameter logic [31:0] COMPARE_INIT = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [31:0] pc,
    input  logic        is_syscall,
    input  logic        is_eret,
    output logic [31:0] excptype,
    output logic [31:0] epc,
    output logic        timer_int
);
    logic [31:0] count, compare, epc_r;
    logic        ie, exl, im7, ti, tick;
    logic [4:0]  exccode;
    logic        wr_count, wr_cmp, wr_status, wr_epc, evt;

    assign wr_count  = we && waddr == 5'd9;
    assign wr_cmp    = we && waddr == 5'd11;
    assign wr_status = we && waddr == 5'd12;
    assign wr_epc    = we && waddr == 5'd14;

    assign excptype  = is_eret ? 32'h4 : is_syscall ? 32'h2 : (ti && im7 && ie && !exl) ? 32'h1 : 32'h0;
    assign evt       = |excptype;
    assign epc       = epc_r;
    assign timer_int = ti;

`ifdef CP0_CNT_DIV2_EN
    // Count and the timer compare only act on edges where the toggle is set
    logic tog;
    assign tick = tog;
    always_ff @(posedge clk or posedge rst)
        if (rst) tog <= 1'b0;
        else     tog <= wr_count ? 1'b0 : ~tog;
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= COUNT_INIT;
            compare <= COMPARE_INIT;
            ie      <= 1'b0;
            exl     <= 1'b0;
            im7     <= 1'b0;
            ti      <= 1'b0;
            exccode <= 5'd0;
            epc_r   <= 32'h0;
        end else begin
            count   <= wr_count ? wdata : count + {31'b0, tick};
            compare <= wr_cmp ? wdata : compare;
            // a Compare write clears TI and beats a same-edge match
            ti      <= wr_cmp ? 1'b0 : ti | (tick && count == compare && compare != 32'h0);
            ie      <= wr_status ? wdata[0] : ie;
            im7     <= wr_status ? wdata[15] : im7;
            // events own EXL/EPC/ExcCode over a concurrent mtc0
            exl     <= excptype[2] ? 1'b0 : evt ? 1'b1 : wr_status ? wdata[1] : exl;
            exccode <= excptype[1] ? 5'd8 : excptype[0] ? 5'd0 : exccode;
            epc_r   <= excptype[2] ? epc_r :
                       excptype[1] ? (exl ? epc_r : pc + 32'd4) :
                       excptype[0] ? pc :
                       wr_epc ? wdata : epc_r;
        end
    end

    always_comb
        rdata = raddr == 5'd9  ? count :
                raddr == 5'd11 ? compare :
                raddr == 5'd12 ? {16'b0, im7, 13'b0, exl, ie} :
                raddr == 5'd13 ? {1'b0, ti, 14'b0, ti, 8'b0, exccode, 2'b0} :
                raddr == 5'd14 ? epc_r : 32'h0;
endmodule
